// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP slice as a signed multiply-accumulate engine for dot products.
// A (valid, first) tag pipeline follows each operand pair through the slice so the CEs line up with the data.
module dsp_mac_sequencer #(
  parameter int LEN_W = 8,
  parameter int M_TAP = 2,
  parameter int P_TAP = 3
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic signed [17:0] op_a,
  input  logic signed [17:0] op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [47:0]       res_data,
  output logic              res_ovf,
  output logic [17:0]       dsp_a,
  output logic [17:0]       dsp_b,
  output logic [7:0]        dsp_opmode,
  output logic              dsp_cea,
  output logic              dsp_ceb,
  output logic              dsp_cem,
  output logic              dsp_ceopmode,
  output logic              dsp_cep,
  output logic              dsp_rstp,
  input  logic [47:0]       dsp_p,
  input  logic              dsp_carryout,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and ready here is a registered function of state only.

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  localparam int DW = $clog2(P_TAP + 2);

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic             first;
  logic [DW-1:0]    dcnt;
  logic [P_TAP:0]   tag_vld;
  logic [P_TAP:0]   tag_first;
  logic             chk_ovf;
  logic             ovf_acc;
  logic             hs;

  assign hs           = op_valid & op_ready;
  assign dsp_cea      = tag_vld[0];
  assign dsp_ceb      = tag_vld[0];
  assign dsp_cem      = tag_vld[M_TAP];
  assign dsp_ceopmode = tag_vld[P_TAP-1];
  assign dsp_cep      = tag_vld[P_TAP];
  assign dbg_state    = state;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state      <= IDLE;
      cnt        <= '0;
      first      <= 1'b0;
      dcnt       <= '0;
      tag_vld    <= '0;
      tag_first  <= '0;
      chk_ovf    <= 1'b0;
      ovf_acc    <= 1'b0;
      busy       <= 1'b0;
      op_ready   <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_ovf    <= 1'b0;
      dsp_a      <= '0;
      dsp_b      <= '0;
      dsp_opmode <= '0;
      dsp_rstp   <= 1'b1;
    end else begin
      dsp_rstp   <= 1'b0;
      tag_vld    <= {tag_vld[P_TAP-1:0], hs};
      tag_first  <= {tag_first[P_TAP-1:0], hs & first};
      // Opmode register lands in the same cycle as ceopmode for its tag.
      dsp_opmode <= tag_vld[P_TAP-2] ? (tag_first[P_TAP-2] ? 8'h01 : 8'h09) : 8'h00;
      // CARRYOUT is registered with P, so it is judged one cycle after an accumulating load.
      chk_ovf    <= tag_vld[P_TAP] & ~tag_first[P_TAP];
      if (chk_ovf && dsp_carryout) ovf_acc <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            ovf_acc <= 1'b0;
            res_ovf <= 1'b0;
            busy    <= 1'b1;
            if (len == '0) begin
              state     <= DONE;
              res_data  <= '0;
              res_valid <= 1'b1;
              dsp_rstp  <= 1'b1;
            end else begin
              state    <= RUN;
              cnt      <= len;
              first    <= 1'b1;
              op_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs) begin
            dsp_a <= op_a;
            dsp_b <= op_b;
            first <= 1'b0;
            cnt   <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
              op_ready <= 1'b0;
              state    <= DRAIN;
              dcnt     <= '0;
            end
          end
        end
        DRAIN: begin
          dcnt <= dcnt + DW'(1);
          // dsp_p holds the final sum one cycle after the last cep.
          if (dcnt == DW'(P_TAP + 1)) begin
            res_data  <= dsp_p;
            res_ovf   <= ovf_acc | (chk_ovf & dsp_carryout);
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP slice (A/B, M, OPMODE, P registers).
module tb_dsp_mac_sequencer;
  localparam int LEN_W = 8;
  localparam int M_TAP = 2;
  localparam int P_TAP = 3;

  logic              CLK = 1'b0;
  logic              RSTN = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              busy;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic signed [17:0] op_a = '0;
  logic signed [17:0] op_b = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [47:0]       res_data;
  logic              res_ovf;
  logic [17:0]       dsp_a, dsp_b;
  logic [7:0]        dsp_opmode;
  logic              dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep, dsp_rstp;
  logic [47:0]       dsp_p;
  logic              dsp_carryout;
  logic [1:0]        dbg_state;

  always #5 CLK = ~CLK;

  dsp_mac_sequencer #(.LEN_W(LEN_W), .M_TAP(M_TAP), .P_TAP(P_TAP)) dut (
    .CLK(CLK), .RSTN(RSTN), .start(start), .len(len), .busy(busy),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
    .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb), .dsp_cem(dsp_cem), .dsp_ceopmode(dsp_ceopmode),
    .dsp_cep(dsp_cep), .dsp_rstp(dsp_rstp), .dsp_p(dsp_p), .dsp_carryout(dsp_carryout),
    .dbg_state(dbg_state)
  );

  // Behavioural slice: first A/B stage gated by CE, later stages free-running.
  logic signed [17:0] sa [M_TAP];
  logic signed [17:0] sb [M_TAP];
  logic signed [47:0] sm;
  logic [47:0]        sp;
  logic [7:0]         sopm;
  logic               scarry;

  assign dsp_p        = sp;
  assign dsp_carryout = scarry;

  always @(posedge CLK) begin
    if (dsp_cea) sa[0] <= dsp_a;
    if (dsp_ceb) sb[0] <= dsp_b;
    for (int k = 1; k < M_TAP; k++) begin
      sa[k] <= sa[k-1];
      sb[k] <= sb[k-1];
    end
    if (dsp_cem) sm <= sa[M_TAP-1] * sb[M_TAP-1];
    if (dsp_ceopmode) sopm <= dsp_opmode;
    if (dsp_rstp) begin
      sp     <= '0;
      scarry <= 1'b0;
    end else if (dsp_cep) begin
      if (sopm == 8'h01) begin
        sp     <= sm;
        scarry <= 1'b0;
      end else begin
        {scarry, sp} <= {1'b0, sp} + {1'b0, sm};
      end
    end
  end

  // Event counters and cycle stamps.
  int cyc = 0, cea_cnt = 0, ceb_cnt = 0, cem_cnt = 0, cep_cnt = 0;
  int last_cea_cyc = 0, rv_rise_cyc = 0, rv_rise_cnt = 0;
  logic rv_prev = 1'b0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (dsp_cea) begin
      cea_cnt      <= cea_cnt + 1;
      last_cea_cyc <= cyc;
    end
    if (dsp_ceb) ceb_cnt <= ceb_cnt + 1;
    if (dsp_cem) cem_cnt <= cem_cnt + 1;
    if (dsp_cep) cep_cnt <= cep_cnt + 1;
    if (res_valid && !rv_prev) begin
      rv_rise_cnt <= rv_rise_cnt + 1;
      rv_rise_cyc <= cyc;
    end
    rv_prev <= res_valid;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic signed [17:0] va [8];
  logic signed [17:0] vb [8];

  task automatic do_cmd(input int l);
    @(negedge CLK);
    start = 1'b1;
    len   = LEN_W'(l);
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic send(input int n, input bit gaps);
    int  i = 0;
    int  g = 0;
    bit  tog = 1'b0;
    while (i < n && g < 100) begin
      @(negedge CLK);
      g++;
      if (gaps && tog) begin
        op_valid = 1'b0;
      end else begin
        op_valid = 1'b1;
        op_a     = va[i];
        op_b     = vb[i];
      end
      tog = ~tog;
      if (op_valid && op_ready) i++;
    end
    @(negedge CLK);
    op_valid = 1'b0;
    chk("send_count", 64'(i), 64'(n));
  endtask

  task automatic wait_res();
    int g = 0;
    while (!res_valid && g < 40) begin
      @(negedge CLK);
      g++;
    end
    chk("res_valid_seen", 64'(res_valid), 64'd1);
  endtask

  task automatic take();
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
  endtask

  int snap_cea, snap_ceb, snap_cem, snap_cep, snap_rv;

  initial begin
    // Reset
    repeat (3) @(negedge CLK);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_op_ready", 64'(op_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_cea", 64'(dsp_cea), 64'd0);
    chk("rst_cep", 64'(dsp_cep), 64'd0);
    chk("rst_opmode", 64'(dsp_opmode), 64'd0);
    chk("rst_rstp", 64'(dsp_rstp), 64'd1);
    chk("rst_state", 64'(dbg_state), 64'd0);
    RSTN = 1'b1;
    @(negedge CLK);
    chk("rstp_release", 64'(dsp_rstp), 64'd0);

    // len=4 dense stream: 5+12+21+32 = 70
    va[0] = 18'sd1; va[1] = 18'sd2; va[2] = 18'sd3; va[3] = 18'sd4;
    vb[0] = 18'sd5; vb[1] = 18'sd6; vb[2] = 18'sd7; vb[3] = 18'sd8;
    snap_cep = cep_cnt;
    do_cmd(4);
    chk("run_busy", 64'(busy), 64'd1);
    send(4, 1'b0);
    wait_res();
    chk("dense_data", 64'(res_data), 64'd70);
    chk("dense_ovf", 64'(res_ovf), 64'd0);
    take();
    chk("dense_latency", 64'(rv_rise_cyc - last_cea_cyc), 64'd5);
    chk("dense_cep_pulses", 64'(cep_cnt - snap_cep), 64'd4);
    chk("dense_idle", 64'(busy), 64'd0);

    // Same stream with bubbles
    snap_cep = cep_cnt;
    do_cmd(4);
    send(4, 1'b1);
    wait_res();
    chk("gaps_data", 64'(res_data), 64'd70);
    take();
    chk("gaps_cep_pulses", 64'(cep_cnt - snap_cep), 64'd4);

    // len=1 negative product, then a fresh len=1 must not accumulate onto it
    va[0] = -18'sd3; vb[0] = 18'sd7;
    do_cmd(1);
    send(1, 1'b0);
    wait_res();
    chk("neg_data", 64'(res_data), 64'h0000_FFFF_FFFF_FFEB);
    take();
    va[0] = 18'sd2; vb[0] = 18'sd2;
    do_cmd(1);
    send(1, 1'b0);
    wait_res();
    chk("fresh_data", 64'(res_data), 64'd4);
    take();

    // Carry out of an accumulating add: -1 + -1
    va[0] = -18'sd1; vb[0] = 18'sd1; va[1] = -18'sd1; vb[1] = 18'sd1;
    do_cmd(2);
    send(2, 1'b0);
    wait_res();
    chk("ovf_data", 64'(res_data), 64'h0000_FFFF_FFFF_FFFE);
    chk("ovf_flag", 64'(res_ovf), 64'd1);
    take();

    // len=0
    snap_cea = cea_cnt; snap_ceb = ceb_cnt; snap_cem = cem_cnt; snap_cep = cep_cnt;
    do_cmd(0);
    chk("len0_valid", 64'(res_valid), 64'd1);
    chk("len0_data", 64'(res_data), 64'd0);
    chk("len0_ovf", 64'(res_ovf), 64'd0);
    chk("len0_rstp", 64'(dsp_rstp), 64'd1);
    take();
    chk("len0_rstp_drop", 64'(dsp_rstp), 64'd0);
    repeat (6) @(negedge CLK);
    chk("len0_cea", 64'(cea_cnt - snap_cea), 64'd0);
    chk("len0_ceb", 64'(ceb_cnt - snap_ceb), 64'd0);
    chk("len0_cem", 64'(cem_cnt - snap_cem), 64'd0);
    chk("len0_cep", 64'(cep_cnt - snap_cep), 64'd0);

    // Result held for 10 cycles while start is pulsed
    va[0] = 18'sd5; vb[0] = 18'sd5; va[1] = 18'sd1; vb[1] = 18'sd1;
    do_cmd(2);
    send(2, 1'b0);
    wait_res();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      start = (i == 2 || i == 5);
      len   = 8'd3;
      chk("hold_data", 64'(res_data), 64'd26);
      chk("hold_valid", 64'(res_valid), 64'd1);
    end
    chk("hold_ovf", 64'(res_ovf), 64'd0);
    start = 1'b0;
    @(negedge CLK);
    take();
    repeat (2) @(negedge CLK);
    chk("hold_idle_busy", 64'(busy), 64'd0);
    chk("hold_idle_ready", 64'(op_ready), 64'd0);

    // res_ready already high when the command is issued
    res_ready = 1'b1;
    va[0] = 18'sd2; vb[0] = 18'sd3;
    do_cmd(1);
    send(1, 1'b0);
    wait_res();
    chk("rdy_high_data", 64'(res_data), 64'd6);
    @(negedge CLK);
    res_ready = 1'b0;
    chk("rdy_high_idle", 64'(busy), 64'd0);

    // Reset after 2 of 4 pairs
    va[0] = 18'sd9; vb[0] = 18'sd9; va[1] = 18'sd8; vb[1] = 18'sd8;
    do_cmd(4);
    send(2, 1'b0);
    RSTN = 1'b0;
    @(negedge CLK);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(op_ready), 64'd0);
    chk("mid_rst_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_data", 64'(res_data), 64'd0);
    chk("mid_rst_cem", 64'(dsp_cem), 64'd0);
    chk("mid_rst_cep", 64'(dsp_cep), 64'd0);
    chk("mid_rst_rstp", 64'(dsp_rstp), 64'd1);
    chk("mid_rst_state", 64'(dbg_state), 64'd0);
    RSTN = 1'b1;
    snap_rv = rv_rise_cnt;
    repeat (8) @(negedge CLK);
    chk("mid_rst_no_result", 64'(rv_rise_cnt - snap_rv), 64'd0);
    va[0] = 18'sd3; vb[0] = 18'sd3; va[1] = 18'sd4; vb[1] = 18'sd4;
    do_cmd(2);
    send(2, 1'b0);
    wait_res();
    chk("post_rst_data", 64'(res_data), 64'd25);
    take();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
